// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: baud strobe, serial line, parity
// configuration, read strobe and the received-byte status register.
interface uart_rx_if;
  logic       baud_clk;
  logic       rxd;
  logic       pen;
  logic       psel;
  logic       rd;
  logic [7:0] dout;
  logic       rdy;
  logic       perr;
  logic       ferr;
  logic       oerr;
  logic       busy;

  // Driver of the line/strobes and consumer of the byte register.
  modport master (
    output baud_clk, rxd, pen, psel, rd,
    input  dout, rdy, perr, ferr, oerr, busy
  );

  // The receiver itself.
  modport slave (
    input  baud_clk, rxd, pen, psel, rd,
    output dout, rdy, perr, ferr, oerr, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x (OVS) oversampled deserialiser for 1 start bit,
// 8 data bits LSB first, optional even/odd parity and 1 stop bit.
// The received byte is held with parity/framing/overrun status until the
// host reads it with a single-cycle rd strobe.
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic     sclk,
  input  logic     sclr_n,
  uart_rx_if.slave bus
);

  localparam int            TW       = $clog2(OVS);
  localparam logic [TW-1:0] CNT_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] CNT_ZERO = TW'(0);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity (XOR reduction) of a data byte.
  function automatic logic parity8(input logic [7:0] data);
    return ^data;
  endfunction

  state_t        state_r;
  logic          rxd_meta_r;
  logic          rxd_sync_r;
  logic          rxd_prev_r;
  logic [TW-1:0] cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          pen_r;
  logic          psel_r;
  logic          pbit_err_r;
  logic [7:0]    dout_r;
  logic          rdy_r;
  logic          perr_r;
  logic          ferr_r;
  logic          oerr_r;
  logic          busy_r;

  logic          fall_s;
  logic          tick_mid_s;
  logic          tick_last_s;
  logic          rd_ack_s;

  assign fall_s      = rxd_prev_r & ~rxd_sync_r;
  assign tick_mid_s  = bus.baud_clk & (cnt_r == CNT_MID);
  assign tick_last_s = bus.baud_clk & (cnt_r == CNT_LAST);
  assign rd_ack_s    = bus.rd & rdy_r;

  // Two-flop synchroniser for the asynchronous line plus a history flop for edge detection.
  always_ff @(posedge sclk or negedge sclr_n) begin
    if (!sclr_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= bus.rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Frame FSM with tick/bit counters, shifter and the host-visible byte/status register.
  always_ff @(posedge sclk or negedge sclr_n) begin
    if (!sclr_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      pen_r      <= 1'b0;
      psel_r     <= 1'b0;
      pbit_err_r <= 1'b0;
      dout_r     <= 8'h00;
      rdy_r      <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      oerr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // A host read of a held byte; a completing frame below takes precedence.
      if (rd_ack_s) begin
        rdy_r  <= 1'b0;
        oerr_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_cnt_r <= 3'd0;
          // Only a genuine high-to-low edge starts a frame; a held-low line does not.
          if (fall_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end
        end

        START: begin
          if (tick_mid_s) begin
            cnt_r <= CNT_ZERO;
            if (!rxd_sync_r) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
              pen_r     <= bus.pen;
              psel_r    <= bus.psel;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else if (bus.baud_clk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (tick_last_s) begin
            shift_r <= {rxd_sync_r, shift_r[7:1]};
            cnt_r   <= CNT_ZERO;
            if (bit_cnt_r == 3'd7) begin
              state_r <= pen_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else if (bus.baud_clk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        PARITY: begin
          if (tick_last_s) begin
            pbit_err_r <= rxd_sync_r ^ parity8(shift_r) ^ psel_r;
            cnt_r      <= CNT_ZERO;
            state_r    <= STOP;
          end else if (bus.baud_clk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        STOP: begin
          if (tick_last_s) begin
            dout_r  <= shift_r;
            ferr_r  <= ~rxd_sync_r;
            perr_r  <= pen_r & pbit_err_r;
            rdy_r   <= 1'b1;
            // A read in the completion cycle retires the old byte, so no overrun.
            if (bus.rd) begin
              oerr_r <= 1'b0;
            end else if (rdy_r) begin
              oerr_r <= 1'b1;
            end else begin
              oerr_r <= oerr_r;
            end
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (bus.baud_clk) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout = dout_r;
  assign bus.rdy  = rdy_r;
  assign bus.perr = perr_r;
  assign bus.ferr = ferr_r;
  assign bus.oerr = oerr_r;
  assign bus.busy = busy_r;

endmodule
